proc_sequencer: RTL and testbench

- Autonomous instruction sequencer for the 16-bit bus processor: fetches instruction words from a synchronous program ROM and feeds them to the processor's DIN/Run/Done interface.
- Supplies the second (immediate) word for mvi one cycle after the instruction word, waits for Done, and advances a program counter.
- Halts at an end address or on a HALT opcode, and flags an error if Done never arrives.
- Sits between the program ROM and proc; proc itself is unchanged.

---
 rtl/proc_seq_pkg.sv | 25 ++
 rtl/proc_sequencer_watchdog.sv | 32 +++
 rtl/proc_sequencer.sv | 130 +++++++++++++
 tb/tb_proc_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_seq_pkg.sv
// Shared types and constants for the instruction sequencer that feeds proc.
// Holds the FSM state encoding and the opcode field layout of an instruction word.
package proc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH_I,
        LATCH_IMM,
        ISSUE,
        EXEC,
        HALT,
        ERROR
    } seq_state_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

endpackage

// File: rtl/proc_sequencer_watchdog.sv
// EXEC-phase watchdog: clearable, enabled up-counter with a terminal-count flag.
// tc is high on the enabled cycle whose increment would reach TIMEOUT.
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != CNT_MAX) begin
            count <= count + CNT_ONE;
        end
    end

    assign tc = en && (count == TC_VAL);

endmodule

// File: rtl/proc_sequencer.sv
// Autonomous program-ROM sequencer driving proc's DIN/Run/Done handshake.
// state     | meaning
// IDLE      | waiting for Start after reset
// FETCH     | MemAddr = PC presented to the ROM
// LATCH_I   | instruction word captured; mvi also requests its immediate
// LATCH_IMM | immediate word captured
// ISSUE     | instruction on DIN with a single-cycle Run pulse
// EXEC      | operand held on DIN until Done or watchdog expiry
// HALT      | program finished (end address or HALT opcode)
// ERROR     | Done never arrived within TIMEOUT cycles
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] EndAddr,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] ProcDIN,
    output logic              ProcRun,
    input  logic              ProcDone,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        InstrCount
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   TOP_ADDR = {1'b0, {ADDR_W{1'b1}}};

    seq_state_e        state, state_next;
    logic [ADDR_W-1:0] pc, end_addr;
    logic [DATA_W-1:0] instr_reg, imm_reg, din_reg;
    logic [7:0]        instr_count;
    logic [2:0]        mem_opcode;
    logic              instr_is_mvi;
    logic [ADDR_W:0]   last_wide;
    logic [ADDR_W-1:0] last_addr;
    logic              last_word;
    logic              wd_tc;

    assign mem_opcode   = MemData[OPC_MSB:OPC_LSB];
    assign instr_is_mvi = (instr_reg[OPC_MSB:OPC_LSB] == OP_MVI);
    assign last_wide    = {1'b0, pc} + {{ADDR_W{1'b0}}, instr_is_mvi};
    assign last_addr    = last_wide[ADDR_W-1:0];
    // The top of memory is a hard stop: the program never wraps back to word 0.
    assign last_word    = (last_addr == end_addr) || (last_wide >= TOP_ADDR);

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk (Clock),
        .rst (Reset),
        .clr (state == ISSUE),
        .en  (state == EXEC),
        .tc  (wd_tc)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALT, ERROR: if (Start) state_next = FETCH;
            FETCH:             state_next = LATCH_I;
            LATCH_I: begin
                if (mem_opcode == OP_HALT)     state_next = HALT;
                else if (mem_opcode == OP_MVI) state_next = LATCH_IMM;
                else                           state_next = ISSUE;
            end
            LATCH_IMM:         state_next = ISSUE;
            ISSUE:             state_next = EXEC;
            EXEC: begin
                if (ProcDone)   state_next = last_word ? HALT : FETCH;
                else if (wd_tc) state_next = ERROR;
            end
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= '0;
            end_addr    <= '0;
            instr_reg   <= '0;
            imm_reg     <= '0;
            din_reg     <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, HALT, ERROR: begin
                    if (Start) begin
                        pc          <= StartAddr;
                        end_addr    <= EndAddr;
                        instr_count <= '0;
                    end
                end
                LATCH_I: begin
                    instr_reg <= MemData;
                    if (mem_opcode != OP_HALT) din_reg <= MemData;
                end
                LATCH_IMM: imm_reg <= MemData;
                ISSUE: begin
                    if (instr_is_mvi) din_reg <= imm_reg;
                    if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
                end
                EXEC: begin
                    if (ProcDone && !last_word) pc <= last_addr + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    // mvi needs its immediate address on the bus while the opcode is still being decoded.
    assign MemAddr    = (state == LATCH_I && mem_opcode == OP_MVI) ? pc + ADDR_ONE : pc;
    assign ProcDIN    = din_reg;
    assign ProcRun    = (state == ISSUE);
    assign Busy       = !(state == IDLE || state == HALT || state == ERROR);
    assign Halted     = (state == HALT);
    assign Error      = (state == ERROR);
    assign PC         = pc;
    assign InstrCount = instr_count;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a synchronous ROM model and auto-Done responder.
module tb_proc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_addr = '0;
    logic [4:0]  end_addr = '0;
    logic [4:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic [15:0] proc_din;
    logic        proc_run;
    logic        proc_done;
    logic        busy, halted, error;
    logic [4:0]  pc;
    logic [7:0]  instr_count;

    logic [15:0] rom [32];
    logic        done_en = 1'b0;
    logic        done_auto = 1'b0;
    logic        spur_done = 1'b0;
    logic        run_prev = 1'b0;
    logic [15:0] run_q [$];
    logic [15:0] after_q [$];

    int n_checks = 0;
    int n_errors = 0;

    assign proc_done = done_auto | spur_done;

    proc_sequencer #(.ADDR_W(5), .DATA_W(16), .TIMEOUT(15)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Start      (start),
        .StartAddr  (start_addr),
        .EndAddr    (end_addr),
        .MemAddr    (mem_addr),
        .MemData    (mem_data),
        .ProcDIN    (proc_din),
        .ProcRun    (proc_run),
        .ProcDone   (proc_done),
        .Busy       (busy),
        .Halted     (halted),
        .Error      (error),
        .PC         (pc),
        .InstrCount (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= rom[mem_addr];

    // Done is returned in the first EXEC cycle: one cycle after the Run pulse.
    initial begin
        forever begin
            @(negedge clk);
            done_auto = done_en && run_prev;
            if (run_prev) after_q.push_back(proc_din);
            if (proc_run) run_q.push_back(proc_din);
            run_prev = proc_run;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns just after the edge that accepts Start.
    task automatic do_start(input logic [4:0] sa, input logic [4:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'hE000;
    endtask

    initial begin
        fill_rom();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_busy",   busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error",  error, 0);
        chk("rst_pc",     pc, 0);
        chk("rst_count",  instr_count, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_din",    proc_din, 0);
        chk("rst_run",    proc_run, 0);

        // mvi R0,5 ; mv R1,R0
        rom[0] = 16'h2000; rom[1] = 16'h0005; rom[2] = 16'h0400;
        done_en = 1'b1;
        run_q.delete(); after_q.delete();
        do_start(5'd0, 5'd2);
        chk("p1_busy", busy, 1);
        chk("p1_fetch_addr", mem_addr, 0);
        step(8);
        chk("p1_not_yet", halted, 0);
        step(1);
        chk("p1_halted", halted, 1);
        chk("p1_busy_end", busy, 0);
        chk("p1_count", instr_count, 2);
        chk("p1_pc", pc, 2);
        chk("p1_runs", run_q.size(), 2);
        if (run_q.size() == 2 && after_q.size() >= 1) begin
            chk("p1_din_run0", run_q[0], 16'h2000);
            chk("p1_din_imm",  after_q[0], 16'h0005);
            chk("p1_din_run1", run_q[1], 16'h0400);
        end

        // HALT opcode at the first word
        fill_rom();
        run_q.delete();
        do_start(5'd0, 5'd5);
        step(1);
        chk("h_not_yet", halted, 0);
        step(1);
        chk("h_halted", halted, 1);
        chk("h_busy", busy, 0);
        chk("h_count", instr_count, 0);
        chk("h_runs", run_q.size(), 0);

        // Watchdog expiry on an add that never completes
        rom[0] = 16'h4000;
        done_en = 1'b0;
        do_start(5'd0, 5'd0);
        step(17);
        chk("wd_early", error, 0);
        chk("wd_busy_mid", busy, 1);
        step(1);
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 0);
        chk("wd_halted", halted, 0);
        chk("wd_count", instr_count, 1);
        done_en = 1'b1;
        do_start(5'd0, 5'd0);
        chk("wd_clr", error, 0);
        chk("wd_rerun_busy", busy, 1);
        step(4);
        chk("wd_rerun_halt", halted, 1);
        chk("wd_rerun_count", instr_count, 1);
        chk("wd_rerun_pc", pc, 0);

        // mvi at the top of memory takes its immediate from word 0
        fill_rom();
        rom[31] = 16'h2000; rom[0] = 16'h1234;
        do_start(5'd31, 5'd31);
        chk("wr_addr0", mem_addr, 31);
        step(1);
        chk("wr_addr1", mem_addr, 0);
        step(2);
        chk("wr_run", proc_run, 1);
        chk("wr_din_issue", proc_din, 16'h2000);
        step(1);
        chk("wr_din_exec", proc_din, 16'h1234);
        step(1);
        chk("wr_halted", halted, 1);
        chk("wr_pc", pc, 31);
        chk("wr_count", instr_count, 1);

        // Reset during EXEC of add
        fill_rom();
        rom[1] = 16'h4000; rom[2] = 16'h6000;
        done_en = 1'b0;
        do_start(5'd1, 5'd2);
        step(3);
        chk("rs_exec_busy", busy, 1);
        chk("rs_exec_pc", pc, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rs_run", proc_run, 0);
        chk("rs_busy", busy, 0);
        chk("rs_pc", pc, 0);
        chk("rs_count", instr_count, 0);
        chk("rs_din", proc_din, 0);
        done_en = 1'b1;
        run_q.delete();
        do_start(5'd1, 5'd2);
        step(8);
        chk("rs_after_halt", halted, 1);
        chk("rs_after_count", instr_count, 2);
        chk("rs_after_pc", pc, 2);
        chk("rs_after_runs", run_q.size(), 2);

        // Start while busy plus a spurious Done in FETCH
        run_q.delete();
        do_start(5'd1, 5'd2);
        start_addr = 5'd5; end_addr = 5'd5;
        start = 1'b1; spur_done = 1'b1;
        step(1);
        start = 1'b0; spur_done = 1'b0;
        chk("sp_pc", pc, 1);
        chk("sp_busy", busy, 1);
        step(7);
        chk("sp_halt", halted, 1);
        chk("sp_count", instr_count, 2);
        chk("sp_final_pc", pc, 2);
        chk("sp_runs", run_q.size(), 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
